// File: rtl/execute_md_pkg.sv
// Shared types and ALU opcodes for the execute stage with iterative multiplier.
package execute_md_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

endpackage

// File: rtl/shift_add_mul.sv
// Radix-2 shift-add unsigned multiplier, one partial product per cycle, N cycles.
// EXECUTE_MD_MULH_EN widens the accumulator to 2N so the high half can be returned.
module shift_add_mul #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic         hi_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] product_o
);

`ifdef EXECUTE_MD_MULH_EN
  localparam int ACC_W = 2 * N;
`else
  localparam int ACC_W = N;
`endif
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [ACC_W-1:0] sum;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             hi_q, hi_d;

  assign sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CNT_LAST);

`ifdef EXECUTE_MD_MULH_EN
  assign product_o = hi_q ? sum[2*N-1:N] : sum[N-1:0];
`else
  logic unused_hi;
  assign unused_hi = hi_q;
  assign product_o = sum;
`endif

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d   = 1'b1;
      acc_d    = '0;
      mcand_d  = ACC_W'(a_i);
      mplier_d = b_i;
      cnt_d    = '0;
      hi_d     = hi_i;
    end else if (busy_q) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
    end
  end

endmodule

// File: rtl/execute_md.sv
// Execute stage: single-cycle ALU/branch adder plus a stalling N-cycle multiplier.
// Define EXECUTE_MD_MULH_EN to honour MulHigh (upper half of the product).
module execute_md
  import execute_md_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         flush_E,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic         MulOp,
  input  logic         MulHigh,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic         stall_E,
  output logic         valid_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M,
  output logic         zero_M
);

  state_e       state_q, state_d;
  logic [N-1:0] b_op, alu_res, pc_branch;
  logic         mul_start, mul_busy, mul_done;
  logic [N-1:0] mul_product;

  logic [N-1:0] pcb_lat_q, pcb_lat_d, wd_lat_q, wd_lat_d;
  logic         valid_q, valid_d, zero_q, zero_d;
  logic [N-1:0] alu_q, alu_d, pcb_q, pcb_d, wd_q, wd_d;

  assign b_op      = AluSrc ? signImm_E : readData2_E;
  assign pc_branch = PC_E + (signImm_E << 2);
  assign mul_start = (state_q == S_IDLE) && valid_E && MulOp && !flush_E;

  always_comb begin
    case (AluControl)
      ALU_AND:   alu_res = readData1_E & b_op;
      ALU_OR:    alu_res = readData1_E | b_op;
      ALU_ADD:   alu_res = readData1_E + b_op;
      ALU_SUB:   alu_res = readData1_E - b_op;
      ALU_PASSB: alu_res = b_op;
      ALU_NOR:   alu_res = ~(readData1_E | b_op);
      default:   alu_res = '0;
    endcase
  end

  shift_add_mul #(.N(N)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start),
    .abort_i   (flush_E),
    .hi_i      (MulHigh),
    .a_i       (readData1_E),
    .b_i       (b_op),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_comb begin
    state_d = state_q;
    stall_E = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mul_start) begin
          state_d = S_MUL;
          stall_E = 1'b1;
        end
      end
      S_MUL: begin
        stall_E = 1'b1;
        if (mul_done || !mul_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_E) state_d = S_IDLE;
  end

  // Branch target and store data are captured at accept; the inputs may move during MUL.
  assign pcb_lat_d = mul_start ? pc_branch   : pcb_lat_q;
  assign wd_lat_d  = mul_start ? readData2_E : wd_lat_q;

  always_comb begin
    valid_d = 1'b0;
    alu_d   = alu_q;
    pcb_d   = pcb_q;
    wd_d    = wd_q;
    zero_d  = zero_q;
    if (!flush_E) begin
      if (state_q == S_IDLE && valid_E && !MulOp) begin
        valid_d = 1'b1;
        alu_d   = alu_res;
        pcb_d   = pc_branch;
        wd_d    = readData2_E;
        zero_d  = (alu_res == '0);
      end else if (state_q == S_MUL && mul_done) begin
        valid_d = 1'b1;
        alu_d   = mul_product;
        pcb_d   = pcb_lat_q;
        wd_d    = wd_lat_q;
        zero_d  = (mul_product == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pcb_lat_q <= '0;
      wd_lat_q  <= '0;
      valid_q   <= 1'b0;
      alu_q     <= '0;
      pcb_q     <= '0;
      wd_q      <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcb_lat_q <= pcb_lat_d;
      wd_lat_q  <= wd_lat_d;
      valid_q   <= valid_d;
      alu_q     <= alu_d;
      pcb_q     <= pcb_d;
      wd_q      <= wd_d;
      zero_q    <= zero_d;
    end
  end

  assign valid_M     = valid_q;
  assign aluResult_M = alu_q;
  assign PCBranch_M  = pcb_q;
  assign writeData_M = wd_q;
  assign zero_M      = zero_q;

endmodule

// File: tb/tb_execute_md.sv
// Scoreboard bench for execute_md: directed cases plus randomized ALU/multiply traffic.
module tb_execute_md;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_E = 1'b0, flush_E = 1'b0, AluSrc = 1'b0, MulOp = 1'b0, MulHigh = 1'b0;
  logic [3:0]   AluControl = 4'b0;
  logic [N-1:0] PC_E = '0, signImm_E = '0, readData1_E = '0, readData2_E = '0;
  logic         stall_E, valid_M, zero_M;
  logic [N-1:0] PCBranch_M, aluResult_M, writeData_M;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] res;
    logic [N-1:0] pcb;
    logic [N-1:0] wd;
    logic         z;
  } exp_t;

  exp_t exp_q[$];

  execute_md #(.N(N)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E),
    .AluSrc(AluSrc), .AluControl(AluControl), .MulOp(MulOp), .MulHigh(MulHigh),
    .PC_E(PC_E), .signImm_E(signImm_E), .readData1_E(readData1_E), .readData2_E(readData2_E),
    .stall_E(stall_E), .valid_M(valid_M), .PCBranch_M(PCBranch_M),
    .aluResult_M(aluResult_M), .writeData_M(writeData_M), .zero_M(zero_M)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [N-1:0] model_alu(input logic [3:0] code, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    case (code)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return b;
      4'd12:   return ~(a | b);
      default: return '0;
    endcase
  endfunction

  function automatic logic [N-1:0] model_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic hi);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
`ifdef EXECUTE_MD_MULH_EN
    if (hi) return p[2*N-1:N];
`endif
    return p[N-1:0];
  endfunction

  always @(negedge clk) begin
    if (!reset && valid_M) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_M actual=%h required=no_output", aluResult_M);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("aluResult_M", aluResult_M, e.res);
        chk("PCBranch_M", PCBranch_M, e.pcb);
        chk("writeData_M", writeData_M, e.wd);
        chk("zero_M", N'(zero_M), N'(e.z));
      end
    end
  end

  // Entered and left at posedge+1; inputs held for the whole stall window.
  task automatic issue(input logic mul, input logic [3:0] code, input logic src, input logic hi,
                       input logic [N-1:0] pc, input logic [N-1:0] imm,
                       input logic [N-1:0] r1, input logic [N-1:0] r2);
    exp_t e;
    logic [N-1:0] b;
    int stall_cnt, early;
    valid_E = 1'b1; MulOp = mul; AluControl = code; AluSrc = src; MulHigh = hi;
    PC_E = pc; signImm_E = imm; readData1_E = r1; readData2_E = r2;
    b = src ? imm : r2;
    e.res = mul ? model_mul(r1, b, hi) : model_alu(code, r1, b);
    e.pcb = pc + (imm << 2);
    e.wd  = r2;
    e.z   = (e.res == '0);
    exp_q.push_back(e);
    if (mul) begin
      stall_cnt = 0;
      early = 0;
      for (int i = 0; i < N + 1; i++) begin
        @(negedge clk);
        if (stall_E) stall_cnt++;
        if (i > 0 && valid_M) early++;
        @(posedge clk);
      end
      chk("mul_stall_cycles", N'(stall_cnt), N'(N + 1));
      chk("mul_early_valid", N'(early), '0);
    end else begin
      @(negedge clk);
      chk("alu_stall", N'(stall_E), '0);
      @(posedge clk);
    end
    #1;
    valid_E = 1'b0; MulOp = 1'b0; MulHigh = 1'b0;
  endtask

  task automatic abort_mul(input logic use_reset, input int iters,
                           input logic [N-1:0] r1, input logic [N-1:0] r2);
    valid_E = 1'b1; MulOp = 1'b1; AluSrc = 1'b0; MulHigh = 1'b0;
    readData1_E = r1; readData2_E = r2;
    @(posedge clk);
    repeat (iters) @(posedge clk);
    #1;
    valid_E = 1'b0; MulOp = 1'b0;
    if (use_reset) reset = 1'b1; else flush_E = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; flush_E = 1'b0;
    @(negedge clk);
    chk(use_reset ? "reset_stall" : "flush_stall", N'(stall_E), '0);
    chk(use_reset ? "reset_valid" : "flush_valid", N'(valid_M), '0);
    if (use_reset) begin
      chk("reset_aluResult", aluResult_M, '0);
      chk("reset_PCBranch", PCBranch_M, '0);
      chk("reset_writeData", writeData_M, '0);
      chk("reset_zero", N'(zero_M), '0);
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0] codes[7];

  initial begin
    codes[0] = 4'd0; codes[1] = 4'd1; codes[2] = 4'd2; codes[3] = 4'd6;
    codes[4] = 4'd7; codes[5] = 4'd12; codes[6] = 4'd0;

    valid_E = 1'b1; MulOp = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; valid_E = 1'b0; MulOp = 1'b0;
    @(negedge clk);
    chk("por_valid", N'(valid_M), '0);
    chk("por_aluResult", aluResult_M, '0);
    chk("por_PCBranch", PCBranch_M, '0);
    chk("por_stall", N'(stall_E), '0);
    @(posedge clk);
    #1;

    issue(1'b0, 4'b0010, 1'b1, 1'b0, 64'h0, 64'd7, 64'd5, 64'd0);
    issue(1'b0, 4'b0110, 1'b0, 1'b0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 64'h30, 64'h30);
    issue(1'b1, 4'b0000, 1'b0, 1'b0, 64'h40, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    issue(1'b1, 4'b0000, 1'b0, 1'b1, 64'h44, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);

    abort_mul(1'b0, 10, 64'd123, 64'd456);
    issue(1'b0, 4'b0010, 1'b0, 1'b0, 64'h200, 64'd0, 64'd1, 64'd1);
    abort_mul(1'b0, N - 1, 64'd9, 64'd9);
    issue(1'b0, 4'b0001, 1'b0, 1'b0, 64'h204, 64'd2, 64'hF0, 64'h0F);

    abort_mul(1'b1, 30, 64'd77, 64'd88);
    repeat (N + 5) @(posedge clk);
    #1;

    issue(1'b1, 4'b0000, 1'b0, 1'b0, 64'h300, 64'd0, 64'd6, 64'd7);
    issue(1'b0, 4'b0010, 1'b0, 1'b0, 64'h304, 64'd0, 64'd2, 64'd2);
    issue(1'b0, 4'b1111, 1'b0, 1'b0, 64'h308, 64'd5, 64'd9, 64'd9);

    for (int k = 0; k < 60; k++) begin
      int sel;
      logic [N-1:0] r1, r2, imm, pc;
      logic [3:0] code;
      sel = $urandom_range(0, 9);
      r1  = {$urandom, $urandom};
      r2  = {$urandom, $urandom};
      imm = {$urandom, $urandom};
      pc  = {$urandom, $urandom};
      code = codes[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) code = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) r2 = r1;
      if (sel < 2) begin
        if ($urandom_range(0, 1) == 1) r2 = N'($urandom_range(0, 1000));
        issue(1'b1, code, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pc, imm, r1, r2);
      end else if (sel == 9) begin
        @(posedge clk);
        #1;
      end else begin
        issue(1'b0, code, 1'($urandom_range(0, 1)), 1'b0, pc, imm, r1, r2);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", N'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
